fcvt_unit: RTL and testbench
============================

Name: fcvt_unit

Overview:
Multi-cycle single-precision conversion unit for the FP datapath: FCVT.W.S / FCVT.WU.S (float to int) and FCVT.S.W / FCVT.S.WU (int to float).
- Sits beside fpu in EX, sharing operand and result buses. Decodes what the adder encodes, and encodes what the adder consumes.
- Uses an iterative one-bit-per-cycle shifter, a start/busy/done handshake, and RISC-V fflags output.

Parameters:
XLEN, 32, integer and float width; only 32 is supported.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE
op  in  2  00 FCVT.W.S, 01 FCVT.WU.S, 10 FCVT.S.W, 11 FCVT.S.WU
in_a  in  32  operand: float bits or integer
busy  out  1  high from the cycle after accept until FINISH, inclusive
done  out  1  one-cycle pulse; out and flags are valid in that cycle
out  out  32  result; held until the next done
flags  out  5  {NV,DZ,OF,UF,NX}; DZ, OF and UF are always 0; held with out

Behaviour:
- Reset is asynchronous and active-low. It forces state IDLE and busy=done=0, out=0, flags=0, at any time including mid-conversion. There is no partial result.
- States: IDLE, SHIFT, ROUND, FINISH.
  - IDLE: on start, capture op and in_a. Special cases go to FINISH; all others go to SHIFT.
  - start while not IDLE is ignored.
- SHIFT: holds a 32-bit magnitude reg, a 5-bit counter and a sticky bit.
  - Each cycle: if the aligned condition holds, go to ROUND; otherwise shift one bit and increment the counter.
  - k = number of shifts needed.
- ROUND: forms the result, then goes to FINISH.
- FINISH: done=1 for one cycle, then IDLE.
- Latency: done is high k+3 cycles after the start cycle for the normal path, and 1 cycle after start for special cases.
- Int to float (op 1x):
  - in_a==0 is special: out=0x00000000, flags=0.
  - mag = |in_a| for signed, in_a for unsigned. 0x80000000 signed gives mag 0x80000000; sign = in_a[31] & ~op[0].
  - SHIFT left until mag[31]=1; exp = 158 - k.
  - ROUND uses RNE: mant=mag[30:8], guard=mag[7], sticky=|mag[6:0]. Increment if guard & (sticky | mant[0]).
  - Mantissa carry-out sets mant=0 and exp+1. NX = guard | sticky.
  - out = {sign, exp[7:0], mant}.
- Float to int (op 0x): s=in_a[31], e=in_a[30:23], f=in_a[22:0]. Rounding is RTZ.
  - NaN (e=255, f!=0): W gives 0x7FFFFFFF, WU gives 0xFFFFFFFF, NV.
  - ±Inf: W gives 0x7FFFFFFF / 0x80000000, WU gives 0xFFFFFFFF / 0, NV.
  - e<127: out=0. NX if e|f nonzero. Applies to WU negatives too (no NV).
  - W with e>158, or e==158 except exactly 0xCF000000: saturate to 0x7FFFFFFF (s=0) or 0x80000000 (s=1), NV.
  - 0xCF000000 gives 0x80000000, flags 0.
  - WU with e>158: 0xFFFFFFFF if s=0, 0 if s=1, NV.
  - WU with s=1 and e>=127: out=0, NV.
  - All of the above are special cases.
  - Otherwise: mag = {1,f,8'b0}, k = 158 - e (0..31). SHIFT right k times, ORing shifted-out bits into sticky.
  - ROUND: out = s ? -mag : mag. NX = sticky.
- All arithmetic is unsigned on 32-bit mag. exp is held in 9 bits internally, with no wrap for valid ranges.

Decomposition:
- fpu_pkg holds:
  - op encodings FCVT_W_S, FCVT_WU_S, FCVT_S_W, FCVT_S_WU, alongside the existing `FADD.
  - state enum.
  - flag bit indices FLAG_NV=4 .. FLAG_NX=0.
  - constants F_BIAS=127, F_EXP_INT=158, CANON_NAN=0x7FC00000, INT_MAX/INT_MIN/UINT_MAX.
- One combinational sub-module, fcvt_round_rne: inputs mant, guard, sticky, exp; outputs rounded mant, exp, nx. It is reusable by fpu rounding later.

Test Plan:
1. FCVT.S.W in_a=0x00000001 -> out=0x3F800000, flags=0, done exactly 34 cycles after start (k=31).
2. FCVT.S.W 0x01000001 -> 0x4B800000, NX=1 (tie to even, rounds down). FCVT.S.WU 0xFFFFFFFF -> 0x4F800000, NX=1 (carry bumps exponent), done 3 cycles after start.
3. FCVT.W.S 0xC0700000 (-3.75) -> 0xFFFFFFFD, NX. FCVT.W.S 0x3F000000 -> 0, NX, done 1 cycle after start. FCVT.W.S 0x00000000 -> 0, flags 0.
4. Saturation:
   - FCVT.W.S 0x4F000000 -> 0x7FFFFFFF, NV.
   - FCVT.W.S 0xCF000000 -> 0x80000000, flags 0.
   - FCVT.W.S 0x7FC00000 -> 0x7FFFFFFF, NV.
   - FCVT.WU.S 0xBF800000 -> 0, NV.
   - FCVT.WU.S 0xFF800000 -> 0, NV.
5. start re-pulsed with a different operand while busy -> ignored, and the first result is returned unchanged. Back-to-back start in the cycle after done -> accepted.
6. Assert reset during SHIFT -> busy=done=0, out=0, flags=0 immediately (async). After release, a new FCVT.S.W 0xFFFFFFFF -> 0xBF800000, flags 0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP datapath: conversion op encodings, the
// conversion FSM state type, fflags bit positions and IEEE-754 single
// precision / integer boundary constants.
package fpu_pkg;

   // Conversion op field as presented on the 2-bit op port of fcvt_unit.
   // op[1] selects direction (1 = int to float), op[0] selects unsigned.
   localparam logic [1:0] FCVT_W_S  = 2'b00;
   localparam logic [1:0] FCVT_WU_S = 2'b01;
   localparam logic [1:0] FCVT_S_W  = 2'b10;
   localparam logic [1:0] FCVT_S_WU = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_ROUND  = 2'd2,
      ST_FINISH = 2'd3
   } fcvt_state_t;

   // fflags = {NV, DZ, OF, UF, NX}
   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   localparam logic [8:0]  F_BIAS     = 9'd127;
   // Biased exponent of a float whose integer part occupies bit 31.
   localparam logic [8:0]  F_EXP_INT  = 9'd158;
   localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
   localparam logic [31:0] INT_MAX    = 32'h7FFF_FFFF;
   localparam logic [31:0] INT_MIN    = 32'h8000_0000;
   localparam logic [31:0] UINT_MAX   = 32'hFFFF_FFFF;
   // -2^31 as a float: the only e==158 value that fits a signed word.
   localparam logic [31:0] F_INT_MIN  = 32'hCF00_0000;

   function automatic logic [4:0] make_flags(input logic nv, input logic nx);
      logic [4:0] f;
      f          = '0;
      f[FLAG_NV] = nv;
      f[FLAG_NX] = nx;
      return f;
   endfunction

endpackage

// File: rtl/fcvt_round_rne.sv
// Round-to-nearest-even step for a normalised single-precision mantissa.
// Ports:
//   mant      23-bit fraction before rounding
//   guard     first bit below the fraction LSB
//   sticky    OR of all bits below guard
//   exp       9-bit biased exponent before rounding
//   mant_rnd  rounded fraction (zero on carry-out)
//   exp_rnd   exponent, bumped by one on mantissa carry-out
//   nx        inexact: any discarded bit was set
module fcvt_round_rne (
   input  logic [22:0] mant,
   input  logic        guard,
   input  logic        sticky,
   input  logic [8:0]  exp,
   output logic [22:0] mant_rnd,
   output logic [8:0]  exp_rnd,
   output logic        nx
);

   logic        inc;
   logic [23:0] sum;

   assign inc      = guard & (sticky | mant[0]);
   assign sum      = {1'b0, mant} + {23'b0, inc};
   // On carry-out sum[22:0] is already zero, which is the renormalised fraction.
   assign mant_rnd = sum[22:0];
   assign exp_rnd  = exp + {8'b0, sum[23]};
   assign nx       = guard | sticky;

endmodule

// File: rtl/fcvt_unit.sv
// Multi-cycle single-precision <-> 32-bit integer converter
// (FCVT.W.S, FCVT.WU.S, FCVT.S.W, FCVT.S.WU) with one-bit-per-cycle
// normalise/denormalise shifter and RISC-V fflags.
// Ports:
//   clock   system clock
//   reset   asynchronous active-low reset
//   start   request pulse, only sampled while idle
//   op      conversion select (see fpu_pkg)
//   in_a    operand: float bits or integer
//   busy    high from the cycle after accept through FINISH
//   done    one-cycle pulse, out/flags valid
//   out     result, held until the next done
//   flags   {NV,DZ,OF,UF,NX}
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start; special operands resolved directly
// ST_SHIFT  | one-bit shift per cycle until aligned
// ST_ROUND  | RNE (int->float) or RTZ negate (float->int); result latched
// ST_FINISH | done pulse, back to idle
module fcvt_unit
   import fpu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] in_a,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] out,
   output logic [4:0]      flags
);

   fcvt_state_t     state;
   logic            i2f_r;
   logic            sign_r;
   logic [31:0]     mag_r;
   logic [4:0]      cnt_r;
   logic [4:0]      k_r;
   logic            sticky_r;
   logic [XLEN-1:0] out_r;
   logic [4:0]      flags_r;

   // Operand decode in IDLE
   logic        sgn;
   logic [7:0]  e;
   logic [22:0] f;
   logic        sp_hit;
   logic        sp_nv;
   logic        sp_nx;
   logic [31:0] sp_out;
   logic        init_sign;
   logic [31:0] init_mag;
   logic [4:0]  init_k;

   always_comb begin
      sgn       = in_a[31];
      e         = in_a[30:23];
      f         = in_a[22:0];
      sp_hit    = 1'b0;
      sp_nv     = 1'b0;
      sp_nx     = 1'b0;
      sp_out    = '0;
      init_sign = 1'b0;
      init_mag  = '0;
      init_k    = '0;
      if (op[1]) begin
         init_sign = in_a[31] & ~op[0];
         // Negating 0x80000000 yields 0x80000000, the correct magnitude.
         init_mag  = init_sign ? (~in_a + 32'd1) : in_a;
         sp_hit    = (in_a == '0);
      end else begin
         init_sign = sgn;
         init_mag  = {1'b1, f, 8'b0};
         init_k    = 5'(F_EXP_INT - {1'b0, e});
         if (e == 8'hFF && f != '0) begin
            sp_hit = 1'b1;
            sp_nv  = 1'b1;
            sp_out = op[0] ? UINT_MAX : INT_MAX;
         end else if ({1'b0, e} < F_BIAS) begin
            // |x| < 1 truncates to zero for both signednesses, never invalid.
            sp_hit = 1'b1;
            sp_nx  = (in_a[30:0] != '0);
         end else if (!op[0]) begin
            if (in_a == F_INT_MIN) begin
               sp_hit = 1'b1;
               sp_out = INT_MIN;
            end else if ({1'b0, e} >= F_EXP_INT) begin
               // Includes infinities (e == 255, f == 0).
               sp_hit = 1'b1;
               sp_nv  = 1'b1;
               sp_out = sgn ? INT_MIN : INT_MAX;
            end
         end else begin
            if (sgn) begin
               sp_hit = 1'b1;
               sp_nv  = 1'b1;
            end else if ({1'b0, e} > F_EXP_INT) begin
               sp_hit = 1'b1;
               sp_nv  = 1'b1;
               sp_out = UINT_MAX;
            end
         end
      end
   end

   logic aligned;
   assign aligned = i2f_r ? mag_r[31] : (cnt_r == k_r);

   logic [22:0] rnd_mant;
   logic [8:0]  rnd_exp;
   logic        rnd_nx;
   logic [8:0]  pre_exp;
   logic        unused_exp_msb;

   assign pre_exp        = F_EXP_INT - {4'b0, cnt_r};
   assign unused_exp_msb = rnd_exp[8];

   fcvt_round_rne u_round (
      .mant     (mag_r[30:8]),
      .guard    (mag_r[7]),
      .sticky   ((|mag_r[6:0]) | sticky_r),
      .exp      (pre_exp),
      .mant_rnd (rnd_mant),
      .exp_rnd  (rnd_exp),
      .nx       (rnd_nx)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         i2f_r    <= 1'b0;
         sign_r   <= 1'b0;
         mag_r    <= '0;
         cnt_r    <= '0;
         k_r      <= '0;
         sticky_r <= 1'b0;
         out_r    <= '0;
         flags_r  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  i2f_r    <= op[1];
                  sign_r   <= init_sign;
                  mag_r    <= init_mag;
                  k_r      <= init_k;
                  cnt_r    <= '0;
                  sticky_r <= 1'b0;
                  if (sp_hit) begin
                     out_r   <= sp_out;
                     flags_r <= make_flags(sp_nv, sp_nx);
                     state   <= ST_FINISH;
                  end else begin
                     state   <= ST_SHIFT;
                  end
               end
            end
            ST_SHIFT: begin
               if (aligned) begin
                  state <= ST_ROUND;
               end else begin
                  if (i2f_r) begin
                     mag_r <= {mag_r[30:0], 1'b0};
                  end else begin
                     mag_r    <= {1'b0, mag_r[31:1]};
                     sticky_r <= sticky_r | mag_r[0];
                  end
                  cnt_r <= cnt_r + 5'd1;
               end
            end
            ST_ROUND: begin
               if (i2f_r) begin
                  out_r   <= {sign_r, rnd_exp[7:0], rnd_mant};
                  flags_r <= make_flags(1'b0, rnd_nx);
               end else begin
                  out_r   <= sign_r ? (~mag_r + 32'd1) : mag_r;
                  flags_r <= make_flags(1'b0, sticky_r);
               end
               state <= ST_FINISH;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy  = (state != ST_IDLE);
   assign done  = (state == ST_FINISH);
   assign out   = out_r;
   assign flags = flags_r;

endmodule

// File: tb/tb_fcvt_unit.sv
module tb_fcvt_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op    = 2'b00;
   logic [31:0] in_a  = '0;
   logic        busy;
   logic        done;
   logic [31:0] out;
   logic [4:0]  flags;

   int n_checks = 0;
   int n_fail   = 0;

   fcvt_unit #(.XLEN(32)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .op    (op),
      .in_a  (in_a),
      .busy  (busy),
      .done  (done),
      .out   (out),
      .flags (flags)
   );

   always #5 clock = ~clock;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: value-level semantics of the conversions.
   function automatic void ref_model(input logic [1:0] o, input logic [31:0] a,
                                     output logic [31:0] r, output logic [4:0] fl,
                                     output int lat);
      logic              neg, s, big, inexact, nv;
      longint unsigned   m, q, rem, half, sig, val;
      int                p, sh, ex;
      logic [7:0]        e;
      r = 0; fl = 0; lat = 1;
      if (o[1]) begin
         neg = a[31] & ~o[0];
         m   = neg ? (64'h1_0000_0000 - {32'b0, a}) : {32'b0, a};
         if (m == 0) return;
         p = 0;
         for (int i = 0; i < 32; i++) if (m[i]) p = i;
         ex = 127 + p;
         inexact = 1'b0;
         if (p > 23) begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            inexact = (rem != 0);
         end else begin
            q = m << (23 - p);
         end
         if (q == (64'd1 << 24)) begin
            q  = q >> 1;
            ex = ex + 1;
         end
         r   = {neg, ex[7:0], q[22:0]};
         fl  = {4'b0, inexact};
         lat = (31 - p) + 3;
      end else begin
         s = a[31];
         e = a[30:23];
         if (e == 8'hFF && a[22:0] != 0) begin
            r = o[0] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            fl = 5'b10000;
            return;
         end
         sig = {40'b0, 1'b1, a[22:0]};
         big = 1'b0; val = 0; inexact = 1'b0; nv = 1'b0;
         if (e >= 159) big = 1'b1;
         else if (e >= 150) val = sig << (e - 150);
         else if (e < 127) inexact = (a[30:0] != 0);
         else begin
            sh = 150 - e;
            val = sig >> sh;
            inexact = ((sig & ((64'd1 << sh) - 1)) != 0);
         end
         if (!o[0]) begin
            if (big || (s ? (val > 64'h8000_0000) : (val > 64'h7FFF_FFFF))) begin
               nv = 1'b1;
               r  = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else r = s ? 32'(64'd0 - val) : val[31:0];
         end else begin
            if (s && (big || val != 0)) begin
               nv = 1'b1; r = 0;
            end else if (big || val > 64'hFFFF_FFFF) begin
               nv = 1'b1; r = 32'hFFFF_FFFF;
            end else r = val[31:0];
         end
         fl  = nv ? 5'b10000 : {4'b0, inexact};
         lat = (nv || e < 127 || a == 32'hCF00_0000) ? 1 : (161 - int'(e));
      end
   endfunction

   // Issue one conversion starting at the next falling edge; optionally
   // re-pulse start with a different operand while the unit is busy.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic poke);
      logic [31:0] er;
      logic [4:0]  ef;
      int          el;
      int          n;
      ref_model(o, a, er, ef, el);
      @(negedge clock);
      op = o; in_a = a; start = 1'b1;
      n = 0;
      do begin
         @(negedge clock);
         n++;
         start = 1'b0;
         if (n == 1) in_a = $urandom;
         if (poke && n == 2 && !done) begin
            start = 1'b1; op = ~o; in_a = ~a;
         end
      end while (!done && n < 60);
      check({tag, ".lat"}, 32'(n), 32'(el));
      check({tag, ".out"}, out, er);
      check({tag, ".flags"}, {27'b0, flags}, {27'b0, ef});
      check({tag, ".busy"}, {31'b0, busy}, 32'd1);
   endtask

   initial begin
      #2;
      check("rst.busy",  {31'b0, busy}, 32'd0);
      check("rst.done",  {31'b0, done}, 32'd0);
      check("rst.out",   out, 32'd0);
      check("rst.flags", {27'b0, flags}, 32'd0);
      @(negedge clock);
      reset = 1'b1;

      run_op("s_w_1",      2'b10, 32'h0000_0001, 1'b0);
      check("t1.out", out, 32'h3F80_0000);
      run_op("s_w_tie",    2'b10, 32'h0100_0001, 1'b0);
      check("t2a.out", out, 32'h4B80_0000);
      run_op("s_wu_max",   2'b11, 32'hFFFF_FFFF, 1'b0);
      check("t2b.out", out, 32'h4F80_0000);
      run_op("s_w_min",    2'b10, 32'h8000_0000, 1'b0);
      run_op("s_w_zero",   2'b10, 32'h0000_0000, 1'b0);
      run_op("w_m375",     2'b00, 32'hC070_0000, 1'b0);
      check("t3a.out", out, 32'hFFFF_FFFD);
      run_op("w_half",     2'b00, 32'h3F00_0000, 1'b0);
      run_op("w_zero",     2'b00, 32'h0000_0000, 1'b0);
      run_op("w_2p31",     2'b00, 32'h4F00_0000, 1'b0);
      check("t4a.out", out, 32'h7FFF_FFFF);
      run_op("w_m2p31",    2'b00, 32'hCF00_0000, 1'b0);
      check("t4b.out", out, 32'h8000_0000);
      run_op("w_nan",      2'b00, 32'h7FC0_0000, 1'b0);
      run_op("wu_m1",      2'b01, 32'hBF80_0000, 1'b0);
      run_op("wu_minf",    2'b01, 32'hFF80_0000, 1'b0);
      run_op("w_pinf",     2'b00, 32'h7F80_0000, 1'b0);
      run_op("wu_top",     2'b01, 32'h4F7F_FFFF, 1'b0);
      run_op("wu_m_half",  2'b01, 32'hBF00_0000, 1'b0);
      run_op("w_big_neg",  2'b00, 32'hCEFF_FFFF, 1'b0);

      run_op("poke_s_w",   2'b10, 32'h0000_0003, 1'b1);
      run_op("poke_w_s",   2'b00, 32'h4120_0000, 1'b1);

      for (int i = 0; i < 60; i++) begin
         logic [1:0]  ro;
         logic [31:0] ra;
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         if (ro[1]) begin
            if (i % 3 == 0) ra = ra >> $urandom_range(0, 31);
         end else if (i % 4 != 0) begin
            ra[30:23] = 8'($urandom_range(120, 162));
         end
         run_op("rand", ro, ra, 1'b0);
      end

      run_op("pre_rst", 2'b10, 32'h0000_0005, 1'b0);
      @(negedge clock);
      op = 2'b10; in_a = 32'h0000_0001; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (4) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      check("mid_rst.busy",  {31'b0, busy}, 32'd0);
      check("mid_rst.done",  {31'b0, done}, 32'd0);
      check("mid_rst.out",   out, 32'd0);
      check("mid_rst.flags", {27'b0, flags}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      run_op("post_rst", 2'b10, 32'hFFFF_FFFF, 1'b0);
      check("t6.out", out, 32'hBF80_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
